// File: rtl/inputs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inputs_pkg
//  Description : Shared types and constant helpers for the debounced,
//                arbitrated button input block.
//  Revision    : 1.0 - initial release
// ============================================================================
package inputs_pkg;

    // Arbiter / lockout state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Index width that never collapses to zero bits (single-channel builds)
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Largest of three values, used to size the shared down-counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Raw line level when the button is not pressed
    function automatic logic released_level(input int active_low);
        return (active_low != 0) ? 1'b1 : 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inputs_debounced_arb_sync.sv
`default_nettype none
// ============================================================================
//  Module      : input_sync_edge
//  Description : One button channel: two-flop synchroniser, previous-level
//                flop and polarity-aware press-edge detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_sync_edge
    import inputs_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pressed,
    output logic press_edge
);

    localparam logic c_REL = released_level(ACTIVE_LOW);

    logic r_s1;
    logic r_s2;
    logic r_prv;
    logic w_prv_pressed;

    // Synchroniser chain plus previous level; resets to the released level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= c_REL;
            r_s2  <= c_REL;
            r_prv <= c_REL;
        end else begin
            r_s1  <= btn_raw;
            r_s2  <= r_s1;
            r_prv <= r_s2;
        end
    end

    // Normalise polarity and flag the released-to-pressed transition
    always_comb begin
        pressed       = (ACTIVE_LOW != 0) ? ~r_s2  : r_s2;
        w_prv_pressed = (ACTIVE_LOW != 0) ? ~r_prv : r_prv;
        press_edge    = pressed & ~w_prv_pressed;
    end

endmodule
`default_nettype wire

// File: rtl/inputs_debounced_arb.sv
`default_nettype none
// ============================================================================
//  Module      : inputs_debounced_arb
//  Description : NUM_CH button synchronisers, post-reset warm-up masking,
//                fixed-priority arbitration, lockout and optional
//                hold-to-repeat. Emits one-hot single-cycle move pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module inputs_debounced_arb
    import inputs_pkg::*;
#(
    parameter  int NUM_CH        = 3,
    parameter  int LOCKOUT       = 15,
    parameter  int ACTIVE_LOW    = 1,
    parameter  int REPEAT_EN     = 0,
    parameter  int REPEAT_DELAY  = 1000,
    parameter  int REPEAT_PERIOD = 250,
    localparam int IDX_W         = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic              repeat_mode,
    output logic [NUM_CH-1:0] pulse,
    output logic [IDX_W-1:0]  pulse_idx,
    output logic              busy
);

    localparam int CNT_W = $clog2(max3(LOCKOUT, REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CNT_W-1:0] c_LOCK_LOAD   = CNT_W'(LOCKOUT - 1);
    localparam logic [CNT_W-1:0] c_DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    logic [NUM_CH-1:0] w_pressed;
    logic [NUM_CH-1:0] w_edge_raw;
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_owner_mask;
    logic [NUM_CH-1:0] w_cand;
    logic [IDX_W-1:0]  w_win;
    logic              w_owner_pressed;
    logic              w_repeat_on;
    logic [1:0]        r_warm;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  w_owner_nxt;
    logic              w_fire;
    logic [IDX_W-1:0]  w_fire_idx;
    logic [NUM_CH-1:0] r_pulse;
    logic [NUM_CH-1:0] w_pulse_nxt;
    logic [IDX_W-1:0]  r_pulse_idx;
    logic [IDX_W-1:0]  w_pulse_idx_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            input_sync_edge #(
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_sync (
                .clk        (clk),
                .rst        (rst),
                .btn_raw    (btn_in[gi]),
                .pressed    (w_pressed[gi]),
                .press_edge (w_edge_raw[gi])
            );
        end
    endgenerate

    // Warm-up: hide the edges the synchronisers produce while they settle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm <= 2'd0;
        end else if (r_warm != 2'd3) begin
            r_warm <= r_warm + 2'd1;
        end
    end

    // Edge masking, owner decode and fixed-priority winner (lowest index)
    always_comb begin
        w_repeat_on = (REPEAT_EN != 0) ? repeat_mode : 1'b0;
        w_edge      = (r_warm == 2'd3) ? w_edge_raw : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_owner_mask[i] = (IDX_W'(i) == r_owner);
        end
        w_owner_pressed = |(w_pressed & w_owner_mask);
        // In HOLD only another channel may pre-empt; the owner's edge is excluded
        w_cand = (r_state == HOLD) ? (w_edge & ~w_owner_mask) : w_edge;
        w_win  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_cand[i]) w_win = IDX_W'(i);
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_owner     <= '0;
            r_pulse     <= '0;
            r_pulse_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_owner     <= w_owner_nxt;
            r_pulse     <= w_pulse_nxt;
            r_pulse_idx <= w_pulse_idx_nxt;
        end
    end

    // Next-state, counter and owner selection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_fire      = 1'b0;
        w_fire_idx  = '0;
        case (r_state)
            IDLE: begin
                if (|w_cand) begin
                    w_fire      = 1'b1;
                    w_fire_idx  = w_win;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = c_LOCK_LOAD;
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (r_cnt == '0) begin
                    if (w_repeat_on && w_owner_pressed) begin
                        w_cnt_nxt   = c_DELAY_LOAD;
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (|w_cand) begin
                    w_fire      = 1'b1;
                    w_fire_idx  = w_win;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = c_LOCK_LOAD;
                    w_state_nxt = LOCK;
                end else if (!w_owner_pressed || !w_repeat_on) begin
                    // Release goes through LOCK so release bounce is swallowed
                    w_cnt_nxt   = c_LOCK_LOAD;
                    w_state_nxt = LOCK;
                end else if (r_cnt == '0) begin
                    w_fire      = 1'b1;
                    w_fire_idx  = r_owner;
                    w_cnt_nxt   = c_PERIOD_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: one-hot pulse and its index, zero when nothing fires
    always_comb begin
        w_pulse_nxt     = '0;
        w_pulse_idx_nxt = '0;
        if (w_fire) begin
            for (int i = 0; i < NUM_CH; i++) begin
                w_pulse_nxt[i] = (IDX_W'(i) == w_fire_idx);
            end
            w_pulse_idx_nxt = w_fire_idx;
        end
    end

    assign pulse     = r_pulse;
    assign pulse_idx = r_pulse_idx;
    assign busy      = (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_inputs_debounced_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inputs_debounced_arb
//  Description : Directed self-checking bench for inputs_debounced_arb
//                (3 channels, active-low, lockout 15, repeat 40/10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inputs_debounced_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_in;
    logic       repeat_mode;
    logic [2:0] pulse;
    logic [1:0] pulse_idx;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int pc [3] = '{0, 0, 0};
    int s0, s1, s2;

    inputs_debounced_arb #(
        .NUM_CH        (3),
        .LOCKOUT       (15),
        .ACTIVE_LOW    (1),
        .REPEAT_EN     (1),
        .REPEAT_DELAY  (40),
        .REPEAT_PERIOD (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .repeat_mode (repeat_mode),
        .pulse       (pulse),
        .pulse_idx   (pulse_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Count pulses per channel, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pulse[i] === 1'b1) pc[i]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        btn_in      = 3'b111;
        repeat_mode = 1'b0;
        tick(3);
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_idx",   32'(pulse_idx), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        rst = 1'b0;
        tick(6);

        // Single press on ch1, no repeat
        btn_in[1] = 1'b0;
        tick(2);
        chk("t1_early", 32'(pulse), 32'h0);
        tick(1);
        chk("t1_pulse", 32'(pulse), 32'h2);
        chk("t1_idx",   32'(pulse_idx), 32'h1);
        chk("t1_busy0", 32'(busy), 32'h1);
        tick(1);
        chk("t1_width", 32'(pulse), 32'h0);
        tick(13);
        chk("t1_busy14", 32'(busy), 32'h1);
        tick(1);
        chk("t1_busy15", 32'(busy), 32'h0);
        btn_in[1] = 1'b1;
        tick(5);

        // Simultaneous ch0 and ch2: ch0 wins, ch2 discarded
        s2 = pc[2];
        btn_in = 3'b010;
        tick(3);
        chk("t2_pulse", 32'(pulse), 32'h1);
        chk("t2_idx",   32'(pulse_idx), 32'h0);
        tick(30);
        chk("t2_ch2_never", 32'(pc[2] - s2), 32'h0);
        chk("t2_idle", 32'(busy), 32'h0);
        btn_in = 3'b111;
        tick(5);

        // Bouncing press on ch2: exactly one pulse
        s2 = pc[2];
        for (int i = 0; i < 7; i++) begin
            btn_in[2] = (i % 2 == 1);
            tick(1);
        end
        tick(25);
        chk("t3_one_pulse", 32'(pc[2] - s2), 32'h1);
        btn_in[2] = 1'b1;
        tick(10);

        // Hold-to-repeat on ch0
        repeat_mode = 1'b1;
        s0 = pc[0];
        btn_in[0] = 1'b0;
        tick(3);
        chk("t4_first", 32'(pulse), 32'h1);
        tick(14);
        chk("t4_busy14", 32'(busy), 32'h1);
        tick(1);
        chk("t4_hold", 32'(busy), 32'h0);
        tick(39);
        chk("t4_pre_rep", 32'(pulse), 32'h0);
        tick(1);
        chk("t4_rep1", 32'(pulse), 32'h1);
        chk("t4_rep1_idx", 32'(pulse_idx), 32'h0);
        tick(10);
        chk("t4_rep2", 32'(pulse), 32'h1);
        tick(35);
        chk("t4_count", 32'(pc[0] - s0), 32'd6);
        btn_in[0] = 1'b1;
        tick(3);
        chk("t4_rel_lock", 32'(busy), 32'h1);
        chk("t4_rel_nopulse", 32'(pulse), 32'h0);
        tick(14);
        chk("t4_rel_busy14", 32'(busy), 32'h1);
        tick(1);
        chk("t4_rel_done", 32'(busy), 32'h0);
        chk("t4_count_end", 32'(pc[0] - s0), 32'd6);
        tick(5);

        // ch1 pre-empts a ch0 hold
        s0 = pc[0];
        s1 = pc[1];
        btn_in[0] = 1'b0;
        tick(3);
        chk("t5_first", 32'(pulse), 32'h1);
        tick(20);
        chk("t5_in_hold", 32'(busy), 32'h0);
        btn_in[1] = 1'b0;
        tick(3);
        chk("t5_preempt", 32'(pulse), 32'h2);
        chk("t5_preempt_idx", 32'(pulse_idx), 32'h1);
        chk("t5_preempt_busy", 32'(busy), 32'h1);
        tick(15);
        btn_in[1] = 1'b1;
        tick(50);
        chk("t5_ch0_abandoned", 32'(pc[0] - s0), 32'h1);
        chk("t5_ch1_once", 32'(pc[1] - s1), 32'h1);
        btn_in[0] = 1'b1;
        repeat_mode = 1'b0;
        tick(20);

        // ch1 held through reset: no pulse
        s1 = pc[1];
        btn_in[1] = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(25);
        chk("t6_no_pulse", 32'(pc[1] - s1), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        btn_in[1] = 1'b1;
        tick(5);

        // Reset during LOCK
        s2 = pc[2];
        btn_in[2] = 1'b0;
        tick(3);
        chk("t7_pulse", 32'(pulse), 32'h4);
        chk("t7_idx",   32'(pulse_idx), 32'h2);
        tick(3);
        chk("t7_locked", 32'(busy), 32'h1);
        rst = 1'b1;
        tick(1);
        chk("t7_rst_busy",  32'(busy), 32'h0);
        chk("t7_rst_pulse", 32'(pulse), 32'h0);
        chk("t7_rst_idx",   32'(pulse_idx), 32'h0);
        rst = 1'b0;
        tick(25);
        chk("t7_no_repulse", 32'(pc[2] - s2), 32'h1);
        chk("t7_idle", 32'(busy), 32'h0);
        btn_in[2] = 1'b1;
        tick(5);

        // Normal operation resumes after the reset
        btn_in[1] = 1'b0;
        tick(3);
        chk("t8_pulse", 32'(pulse), 32'h2);
        btn_in[1] = 1'b1;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inputs_debounced_arb.md
Name: inputs_debounced_arb

Overview:
- Parametrised successor to the fixed three-button debouncer.
- Takes NUM_CH raw asynchronous button lines and synchronises each one.
- Detects presses of configurable polarity and arbitrates simultaneous presses by fixed priority.
- Emits at most one single-cycle, one-hot move pulse per lockout window, with optional hold-to-repeat (auto-repeat) for held buttons; feeds the game FSM directly.

Parameters:
- NUM_CH, 3, number of button channels (>=1).
- LOCKOUT, 15, lockout length in clk cycles after an accepted press or a release (>=1).
- ACTIVE_LOW, 1, 1: press = high-to-low transition of the raw line; 0: press = low-to-high.
- REPEAT_EN, 0, 1 builds the auto-repeat logic; 0 ties repeat_on low.
- REPEAT_DELAY, 1000, cycles from lockout end to the first repeat pulse (>=1).
- REPEAT_PERIOD, 250, cycles between subsequent repeat pulses (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- btn_in  in  NUM_CH  raw asynchronous button lines.
- repeat_mode  in  1  run-time auto-repeat enable; ignored when REPEAT_EN=0.
- pulse  out  NUM_CH  registered one-hot press pulse, one cycle wide.
- pulse_idx  out  IDX_W=max(1,$clog2(NUM_CH))  index of the asserted pulse bit; 0 when pulse==0.
- busy  out  1  high while in LOCK.

Behaviour:
- Synchroniser, per channel:
  - 2 FFs (s1, s2) plus a previous-level FF (prv).
  - Reset value = released level (ACTIVE_LOW ? 1 : 0).
  - pressed[i] = ACTIVE_LOW ? ~s2[i] : s2[i].
  - edge[i] = pressed[i] & ~prv_pressed[i].
- Warm-up after reset:
  - 2-bit counter masks all edges for 3 cycles after rst deasserts.
  - prv still tracks s2 during warm-up.
  - A button held through reset therefore produces no pulse.
- Latency: raw change sampled at edge k -> pulse high from edge k+2 to edge k+3, if accepted.
- Arbitration: lowest index with edge set wins; all other simultaneous edges are discarded, not queued.
- repeat_on = REPEAT_EN & repeat_mode, evaluated every cycle.
- One shared down-counter cnt, width $clog2(max(LOCKOUT,REPEAT_DELAY,REPEAT_PERIOD)+1); an owner register of width IDX_W.
- FSM states: IDLE, LOCK, HOLD.
- IDLE:
  - Any masked-in edge -> pulse[winner]=1, owner=winner, cnt=LOCKOUT-1, go to LOCK.
- LOCK:
  - busy=1; all edges ignored; cnt decrements each cycle.
  - At cnt==0: if repeat_on and pressed[owner] -> HOLD with cnt=REPEAT_DELAY-1; otherwise -> IDLE.
  - Exactly LOCKOUT cycles spent in LOCK.
- HOLD (busy=0), in priority order:
  - (a) Edge on any channel other than owner -> accept it exactly as in IDLE (pre-empts the hold).
  - (b) Owner released, or repeat_on low -> LOCK, cnt=LOCKOUT-1, no pulse. This masks release bounce.
  - (c) cnt==0 -> pulse[owner]=1, cnt=REPEAT_PERIOD-1, stay in HOLD.
  - (d) Otherwise decrement cnt.
- Edge on owner's own channel while in HOLD: impossible while the owner is held. A post-release bounce is absorbed by LOCK.
- Reset mid-operation: state=IDLE, cnt=0, owner=0, pulse=0, pulse_idx=0, busy=0, syncs at released level, warm-up restarts. Any in-flight pulse is dropped.
- Outputs are registered; pulse never has more than one bit set.
- NUM_CH=1: pulse_idx is constant 0.

Decomposition:
- Package inputs_pkg:
  - state enum {IDLE, LOCK, HOLD}.
  - function clog2_min1 for IDX_W.
  - function max3 for the counter width.
  - released-level helper.
- Sub-module input_sync_edge: one channel (s1, s2, prv, polarity, edge), instantiated NUM_CH times in a generate loop. Warm-up masking stays in the top.
- Top level: arbitration (priority encoder), FSM, counter.

Test Plan (NUM_CH=3, LOCKOUT=15, ACTIVE_LOW=1, REPEAT_EN=1, REPEAT_DELAY=40, REPEAT_PERIOD=10):
- btn_in[1] falls at edge k, repeat_mode=0 -> pulse=3'b010, pulse_idx=1 at k+2 for 1 cycle; busy high for 15 cycles; then IDLE.
- btn_in[0] and btn_in[2] fall on the same edge -> only pulse=3'b001; the ch2 edge is never reported, even after lockout.
- btn_in[2] bounces 6 times within 10 cycles after the first fall -> exactly one pulse=3'b100.
- repeat_mode=1, btn_in[0] held for 100 cycles after the first pulse at cycle t -> repeat pulses at t+15+40, then every 10 cycles; release -> no pulse, busy for 15 cycles.
- In HOLD of ch0, btn_in[1] falls -> pulse=3'b010 two cycles later; the ch0 hold is abandoned.
- btn_in[1] low throughout rst and after it -> no pulse. rst asserted during LOCK -> busy=0 and state IDLE on the next cycle.
